sender_arbiter: RTL and testbench

- Round-robin arbiter and pacer that shares one 40-bit serial sender between several requesters, e.g. keyboard, mouse, sound-out and attention message sources.
- Captures one requester's word and drives the sender's parallel input (data + valid).
- Holds valid long enough for the slow serial clock domain to sample it.
- Enforces a minimum gap so a new word is never offered while a frame is still shifting out.
- Sits in the fast clock domain, directly in front of the sender.

---
 rtl/sender_arbiter_pkg.sv | 14 +
 rtl/sender_arbiter_rr_pick.sv | 31 +++
 rtl/sender_arbiter.sv | 122 ++++++++++++
 tb/tb_sender_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sender_arbiter_pkg.sv
// Shared definitions for the sender arbiter and the serial sender it feeds.
package sender_arbiter_pkg;

   localparam int DATA_W_DEF = 40;
   localparam int HOLD_CNT_W = 8;
   localparam int GAP_CNT_W  = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      GAP   = 2'd2
   } arb_state_t;

endpackage

// File: rtl/sender_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, wrapping.
module rr_pick
   import sender_arbiter_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] sel,
   output logic          any_req
);

   // Scan upward from ptr modulo N and keep the first hit.
   always_comb begin : pick
      int unsigned idx;
      logic        found;
      idx     = 0;
      found   = 1'b0;
      sel     = ptr;
      any_req = |req;
      for (int unsigned i = 0; i < N; i++) begin
         idx = (32'(ptr) + i) % N;
         if (!found && req[idx]) begin
            found = 1'b1;
            sel   = IW'(idx);
         end
      end
   end

endmodule

// File: rtl/sender_arbiter.sv
// Round-robin arbiter and pacer sharing one serial sender between requesters.
module sender_arbiter
   import sender_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int VALID_HOLD = 4,
   parameter int GAP_CYCLES = 48
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*DATA_W-1:0]  req_data,
   output logic [NUM_REQ-1:0]         ack,
   output logic [DATA_W-1:0]          out_data,
   output logic                       out_valid,
   input  logic                       tx_busy,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       active
);

   localparam int IW = $clog2(NUM_REQ);
   localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(VALID_HOLD - 1);
   // GAP always occupies at least one cycle, so a zero gap behaves like a gap of one.
   localparam logic [GAP_CNT_W-1:0]  GAP_LAST  =
      (GAP_CYCLES == 0) ? '0 : GAP_CNT_W'(GAP_CYCLES - 1);

   arb_state_t              state_q, state_d;
   logic [IW-1:0]           ptr_q, ptr_d;
   logic [HOLD_CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic [GAP_CNT_W-1:0]    gap_cnt_q, gap_cnt_d;
   logic [NUM_REQ-1:0]      ack_q, ack_d;
   logic [DATA_W-1:0]       out_data_q, out_data_d;
   logic                    out_valid_q, out_valid_d;
   logic [IW-1:0]           grant_id_q, grant_id_d;
   logic [IW-1:0]           sel;
   logic                    any_req;

   rr_pick #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_rr_pick (
      .req     (req),
      .ptr     (ptr_q),
      .sel     (sel),
      .any_req (any_req)
   );

   // Next-state, counters and registered outputs.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      hold_cnt_d  = hold_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      ack_d       = '0;
      out_data_d  = out_data_q;
      out_valid_d = 1'b0;
      grant_id_d  = grant_id_q;
      case (state_q)
         IDLE: begin
            if (any_req && !tx_busy) begin
               state_d      = ISSUE;
               out_data_d   = req_data[int'(sel)*DATA_W +: DATA_W];
               ack_d[sel]   = 1'b1;
               grant_id_d   = sel;
               ptr_d        = (sel == IW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
               hold_cnt_d   = '0;
               out_valid_d  = 1'b1;
            end
         end
         ISSUE: begin
            if (hold_cnt_q == HOLD_LAST) begin
               state_d    = GAP;
               hold_cnt_d = '0;
               gap_cnt_d  = '0;
            end else begin
               hold_cnt_d  = hold_cnt_q + 1'b1;
               out_valid_d = 1'b1;
            end
         end
         GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               state_d   = IDLE;
               gap_cnt_d = '0;
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         hold_cnt_q  <= '0;
         gap_cnt_q   <= '0;
         ack_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         grant_id_q  <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         hold_cnt_q  <= hold_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         ack_q       <= ack_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         grant_id_q  <= grant_id_d;
      end
   end

   assign ack       = ack_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign grant_id  = grant_id_q;
   assign active    = (state_q != IDLE);

endmodule

// File: tb/tb_sender_arbiter.sv
// Directed bench for sender_arbiter: grant table plus multi-cycle sequences.
module tb_sender_arbiter;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [3:0]   req = '0;
   logic [159:0] req_data;
   logic [3:0]   ack;
   logic [39:0]  out_data;
   logic         out_valid;
   logic         tx_busy = 1'b0;
   logic [1:0]   grant_id;
   logic         active;

   logic [3:0]   req2 = '0;
   logic [3:0]   ack2;
   logic [39:0]  out_data2;
   logic         out_valid2;
   logic [1:0]   grant_id2;
   logic         active2;

   localparam logic [39:0] W0 = 40'h11_0000_00AA;
   localparam logic [39:0] W1 = 40'h22_DEAD_BEEF;
   localparam logic [39:0] W2 = 40'hA5_1234_5678;
   localparam logic [39:0] W3 = 40'h3C_0F0F_F0F0;

   assign req_data = {W3, W2, W1, W0};

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   sender_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .req_data  (req_data),
      .ack       (ack),
      .out_data  (out_data),
      .out_valid (out_valid),
      .tx_busy   (tx_busy),
      .grant_id  (grant_id),
      .active    (active)
   );

   sender_arbiter #(
      .NUM_REQ    (4),
      .DATA_W     (40),
      .VALID_HOLD (1),
      .GAP_CYCLES (0)
   ) dut_fast (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req2),
      .req_data  (req_data),
      .ack       (ack2),
      .out_data  (out_data2),
      .out_valid (out_valid2),
      .tx_busy   (1'b0),
      .grant_id  (grant_id2),
      .active    (active2)
   );

   typedef struct {
      logic [3:0]  req;
      logic [1:0]  exp_gid;
      logic [3:0]  exp_ack;
      logic [39:0] exp_data;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      req     = '0;
      req2    = '0;
      tx_busy = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int n;
      int last;
      int nr;
      logic pv;
      logic bad;
      int order[5];

      vecs[0] = '{req: 4'b0100, exp_gid: 2'd2, exp_ack: 4'b0100, exp_data: W2};
      vecs[1] = '{req: 4'b1010, exp_gid: 2'd1, exp_ack: 4'b0010, exp_data: W1};
      vecs[2] = '{req: 4'b1000, exp_gid: 2'd3, exp_ack: 4'b1000, exp_data: W3};
      vecs[3] = '{req: 4'b0001, exp_gid: 2'd0, exp_ack: 4'b0001, exp_data: W0};
      vecs[4] = '{req: 4'b1111, exp_gid: 2'd0, exp_ack: 4'b0001, exp_data: W0};
      vecs[5] = '{req: 4'b1100, exp_gid: 2'd2, exp_ack: 4'b0100, exp_data: W2};

      // Reset values
      tick();
      chk("rst_ack", ack, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_active", active, 0);

      // Table: single grant from reset, pulse width and hold length
      for (int v = 0; v < 6; v++) begin
         do_reset();
         req = vecs[v].req;
         tick();
         chk("tbl_ack", ack, vecs[v].exp_ack);
         chk("tbl_grant_id", grant_id, vecs[v].exp_gid);
         chk("tbl_out_data", out_data, vecs[v].exp_data);
         chk("tbl_out_valid", out_valid, 1);
         chk("tbl_active", active, 1);
         req = '0;
         n = 1;
         tick();
         chk("tbl_ack_pulse", ack, 0);
         while (out_valid && n < 300) begin
            n++;
            tick();
         end
         chk("tbl_hold_len", n, 4);
         chk("tbl_gap_active", active, 1);
         chk("tbl_gap_data", out_data, vecs[v].exp_data);
      end

      // All four held: rotation order and 53-cycle spacing
      do_reset();
      order = '{0, 1, 2, 3, 0};
      req = 4'b1111;
      last = 0;
      nr = 0;
      pv = 1'b0;
      for (int c = 0; c < 400 && nr < 5; c++) begin
         tick();
         if (out_valid && !pv) begin
            chk("rr_grant", grant_id, order[nr]);
            chk("rr_ack", ack, 64'd1 << order[nr]);
            if (nr > 0) chk("rr_spacing", c - last, 53);
            last = c;
            nr++;
         end
         pv = out_valid;
      end
      chk("rr_count", nr, 5);

      // tx_busy blocks issue until it falls
      do_reset();
      tx_busy = 1'b1;
      req = 4'b0010;
      bad = 1'b0;
      for (int c = 0; c < 100; c++) begin
         tick();
         if (ack != 0 || out_valid) bad = 1'b1;
      end
      chk("busy_blocked", bad, 0);
      tx_busy = 1'b0;
      tick();
      chk("busy_release_ack", ack, 4'b0010);
      chk("busy_release_valid", out_valid, 1);

      // Request arriving during GAP waits for the gap to finish
      do_reset();
      req = 4'b0001;
      tick();
      chk("gap_first_ack", ack, 4'b0001);
      req = '0;
      for (int c = 0; c < 4; c++) tick();
      chk("gap_in_gap", out_valid, 0);
      req = 4'b0100;
      n = 0;
      bad = 1'b0;
      while (ack == 0 && n < 200) begin
         if (out_data != W0) bad = 1'b1;
         n++;
         tick();
      end
      chk("gap_data_held", bad, 0);
      chk("gap_wait", n, 49);
      chk("gap_grant_id", grant_id, 2);
      chk("gap_new_data", out_data, W2);
      req = '0;

      // Asynchronous reset on the 2nd ISSUE cycle
      do_reset();
      req = 4'b0010;
      tick();
      chk("mid_grant", grant_id, 1);
      req = '0;
      tick();
      chk("mid_issue2_valid", out_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_active", active, 0);
      chk("mid_rst_grant_id", grant_id, 0);
      tick();
      rst_n = 1'b1;
      req = 4'b1010;
      tick();
      chk("mid_ptr_cleared", grant_id, 1);
      req = '0;
      do_reset();
      req = 4'b1000;
      tick();
      chk("mid_req3_ack", ack, 4'b1000);
      chk("mid_req3_data", out_data, W3);

      // VALID_HOLD=1, GAP_CYCLES=0: rises 3 cycles apart, alternating 0/1
      do_reset();
      req2 = 4'b0011;
      last = 0;
      nr = 0;
      pv = 1'b0;
      for (int c = 0; c < 60 && nr < 6; c++) begin
         tick();
         if (out_valid2 && !pv) begin
            chk("fast_grant", grant_id2, nr % 2);
            chk("fast_ack", ack2, 64'd1 << (nr % 2));
            if (nr > 0) chk("fast_spacing", c - last, 3);
            last = c;
            nr++;
         end
         pv = out_valid2;
      end
      chk("fast_count", nr, 6);
      req2 = '0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
